// File: rtl/cla_arbiter.sv
// Round-robin arbiter sharing one carry-lookahead adder/subtractor among NREQ requesters.
// Latency: request accepted at edge T, RSP_VALID high after edge T+1; one operation per 3 cycles at best.
// Backpressure: RSP_* held while RSP_READY is low; REQ_READY stays zero until the response is taken.
//
// Ports: CLK/RST_N (synchronous, active-low reset); REQ_VALID/REQ_READY/REQ_A/REQ_B/REQ_SUB per-requester
// request channel (operands packed, requester k at [k*N +: N]); RSP_VALID/RSP_READY/RSP_ID/RSP_R/RSP_COUT
// response channel; BUSY high outside IDLE.
// Optional feature macro: CLA_ARB_OVF_EN adds the RSP_OVF port (signed overflow) and its register.

module cla #(
    parameter int N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         ADD_SUB,
    output logic [N-1:0] R,
    output logic         COUT
);
    // Operands are padded up to whole 4-bit lookahead groups; padded bits have g=p=0
    // so they never disturb the carry taken from bit N.
    localparam int NB = (N + 3) / 4;
    localparam int NP = NB * 4;

    logic [NP-1:0] g;
    logic [NP-1:0] p;
    logic [NP:0]   c;
    logic          ci;
    logic          grp_g;
    logic          grp_p;

    always_comb begin
        g     = '0;
        p     = '0;
        c     = '0;
        ci    = 1'b0;
        grp_g = 1'b0;
        grp_p = 1'b0;
        // Subtract is A + ~B + 1: invert B and feed the +1 in as carry-in.
        for (int i = 0; i < N; i++) begin
            g[i] = A[i] & (B[i] ^ ADD_SUB);
            p[i] = A[i] ^ (B[i] ^ ADD_SUB);
        end
        c[0] = ADD_SUB;
        for (int k = 0; k < NB; k++) begin
            ci    = c[4*k];
            grp_g = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            c[4*k+1] = g[4*k] | (p[4*k] & ci);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & ci);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & ci);
            c[4*k+4] = grp_g | (grp_p & ci);
        end
    end

    assign R    = p[N-1:0] ^ c[N-1:0];
    assign COUT = c[N];
endmodule

module cla_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   REQ_VALID,
    output logic [NREQ-1:0]   REQ_READY,
    input  logic [NREQ*N-1:0] REQ_A,
    input  logic [NREQ*N-1:0] REQ_B,
    input  logic [NREQ-1:0]   REQ_SUB,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [IDW-1:0]    RSP_ID,
    output logic [N-1:0]      RSP_R,
    output logic              RSP_COUT,
    output logic              BUSY
`ifdef CLA_ARB_OVF_EN
    ,
    output logic              RSP_OVF
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   op_a_q, op_a_d;
    logic [N-1:0]   op_b_q, op_b_d;
    logic           op_sub_q, op_sub_d;
    logic [IDW-1:0] id_q, id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [N-1:0]   rsp_r_q, rsp_r_d;
    logic           rsp_cout_q, rsp_cout_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
`ifdef CLA_ARB_OVF_EN
    logic           rsp_ovf_q, rsp_ovf_d;
    logic [N-1:0]   b_eff;
    logic           ovf_calc;
`endif

    logic [N-1:0]   cla_r;
    logic           cla_cout;

    cla #(.N(N)) u_cla (
        .A       (op_a_q),
        .B       (op_b_q),
        .ADD_SUB (op_sub_q),
        .R       (cla_r),
        .COUT    (cla_cout)
    );

`ifdef CLA_ARB_OVF_EN
    // Overflow when both effective operands share a sign and the result's sign differs.
    assign b_eff    = op_b_q ^ {N{op_sub_q}};
    assign ovf_calc = (op_a_q[N-1] == b_eff[N-1]) && (cla_r[N-1] != op_a_q[N-1]);
`endif

    // Round-robin pick: first valid requester at or above ptr, wrapping modulo NREQ.
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    int             scan_idx;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!gnt_found && REQ_VALID[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sub_d    = op_sub_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_r_d     = rsp_r_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
`ifdef CLA_ARB_OVF_EN
        rsp_ovf_d   = rsp_ovf_q;
`endif
        REQ_READY   = '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    REQ_READY[gnt_idx] = 1'b1;
                    op_a_d   = REQ_A[gnt_idx*N +: N];
                    op_b_d   = REQ_B[gnt_idx*N +: N];
                    op_sub_d = REQ_SUB[gnt_idx];
                    id_d     = gnt_idx;
                    ptr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_r_d     = cla_r;
                rsp_cout_d  = cla_cout;
                rsp_id_d    = id_q;
`ifdef CLA_ARB_OVF_EN
                rsp_ovf_d   = ovf_calc;
`endif
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                // New requests are not looked at here; the grant waits for IDLE.
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A grant during reset would be lost, so no requester may see READY then.
        if (!RST_N) begin
            REQ_READY = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_sub_q    <= 1'b0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_r_q     <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
`ifdef CLA_ARB_OVF_EN
            rsp_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sub_q    <= op_sub_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_r_q     <= rsp_r_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
`ifdef CLA_ARB_OVF_EN
            rsp_ovf_q   <= rsp_ovf_d;
`endif
        end
    end

    assign RSP_VALID = rsp_valid_q;
    assign RSP_R     = rsp_r_q;
    assign RSP_COUT  = rsp_cout_q;
    assign RSP_ID    = rsp_id_q;
    assign BUSY      = (state_q != ST_IDLE);
`ifdef CLA_ARB_OVF_EN
    assign RSP_OVF   = rsp_ovf_q;
`endif
endmodule

// File: tb/tb_cla_arbiter.sv
// Testbench for cla_arbiter: directed scenarios plus a randomized run against a behavioural model.
// Latency: n/a (bench).
// Backpressure: RSP_READY driven by the bench, held low or randomized per scenario.

module tb_cla_arbiter;
    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_sub;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_r;
    logic              rsp_cout;
    logic              busy;
`ifdef CLA_ARB_OVF_EN
    logic              rsp_ovf;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    cla_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready),
        .REQ_A     (req_a),
        .REQ_B     (req_b),
        .REQ_SUB   (req_sub),
        .RSP_VALID (rsp_valid),
        .RSP_READY (rsp_ready),
        .RSP_ID    (rsp_id),
        .RSP_R     (rsp_r),
        .RSP_COUT  (rsp_cout),
        .BUSY      (busy)
`ifdef CLA_ARB_OVF_EN
        ,
        .RSP_OVF   (rsp_ovf)
`endif
    );

    // Reference arithmetic: {carry/no-borrow, result}, from plain integer arithmetic.
    function automatic logic [N:0] ref_sum(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
        logic [N:0] res;
        if (sub) begin
            res[N-1:0] = a - b;
            res[N]     = (a >= b);
        end else begin
            res = {1'b0, a} + {1'b0, b};
        end
        return res;
    endfunction

    function automatic logic ref_ovf(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = sub ? (sa - sb) : (sa + sb);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic logic [N-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_req(input int k, input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
        req_a[k*N +: N] = a;
        req_b[k*N +: N] = b;
        req_sub[k]      = sub;
        req_valid[k]    = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else pass_cnt++;
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if ({rsp_id, rsp_r, rsp_cout} !== '0) $display("FAIL reset_rsp_fields: got id=%h r=%h c=%b want 0", rsp_id, rsp_r, rsp_cout); else pass_cnt++;
`ifdef CLA_ARB_OVF_EN
        chk_cnt++; if (rsp_ovf !== 1'b0) $display("FAIL reset_rsp_ovf: got %b want 0", rsp_ovf); else pass_cnt++;
`endif
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        @(negedge clk);
        set_req(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        rsp_ready = 1'b1;
        #1;
        chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL add_grant: got %b want 0001", req_ready); else pass_cnt++;
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1;
        chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL add_ready_exec: got %b want 0000", req_ready); else pass_cnt++;
        chk_cnt++; if ({busy, rsp_valid} !== 2'b10) $display("FAIL add_exec_state: got busy=%b vld=%b want 1 0", busy, rsp_valid); else pass_cnt++;
        @(negedge clk);
        #1;
        chk_cnt++; if (rsp_valid !== 1'b1) $display("FAIL add_rsp_valid: got %b want 1", rsp_valid); else pass_cnt++;
        chk_cnt++; if ({rsp_id, rsp_r, rsp_cout} !== {2'd0, 32'h0, 1'b1}) $display("FAIL add_rsp: got id=%h r=%h c=%b want 0 0 1", rsp_id, rsp_r, rsp_cout); else pass_cnt++;
`ifdef CLA_ARB_OVF_EN
        chk_cnt++; if (rsp_ovf !== 1'b0) $display("FAIL add_ovf: got %b want 0", rsp_ovf); else pass_cnt++;
`endif
        @(negedge clk);
        #1;
        chk_cnt++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL add_after_hs: got vld=%b busy=%b want 0 0", rsp_valid, busy); else pass_cnt++;
        chk_cnt++; if (rsp_cout !== 1'b1) $display("FAIL add_hold_after_hs: got c=%b want 1", rsp_cout); else pass_cnt++;
    endtask

    task automatic test_sub_ovf();
        int           tk[4]   = '{2, 1, 3, 0};
        logic [N-1:0] ta[4]   = '{32'h5, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7};
        logic [N-1:0] tb[4]   = '{32'h7, 32'h1, 32'h1, 32'h7};
        logic         ts[4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [N-1:0] er[4]   = '{32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0};
        logic         ec[4]   = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic         eo[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [NREQ-1:0] oh;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            set_req(tk[t], ta[t], tb[t], ts[t]);
            rsp_ready = 1'b1;
            oh = '0;
            oh[tk[t]] = 1'b1;
            #1;
            chk_cnt++; if (req_ready !== oh) $display("FAIL sub_grant[%0d]: got %b want %b", t, req_ready, oh); else pass_cnt++;
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            #1;
            chk_cnt++;
            if ({rsp_valid, rsp_id, rsp_r, rsp_cout} !== {1'b1, IDW'(tk[t]), er[t], ec[t]})
                $display("FAIL sub_rsp[%0d]: got v=%b id=%0d r=%h c=%b want 1 %0d %h %b", t, rsp_valid, rsp_id, rsp_r, rsp_cout, tk[t], er[t], ec[t]);
            else pass_cnt++;
`ifdef CLA_ARB_OVF_EN
            chk_cnt++; if (rsp_ovf !== eo[t]) $display("FAIL sub_ovf[%0d]: got %b want %b", t, rsp_ovf, eo[t]); else pass_cnt++;
`else
            if (eo[t] !== ref_ovf(ta[t], tb[t], ts[t])) $display("note: overflow table entry %0d disagrees with model", t);
`endif
        end
    endtask

    task automatic test_round_robin();
        int           grants[$];
        int           gcyc[$];
        int           rids[$];
        int           gi;
        logic [N-1:0] oa[NREQ];
        logic [N-1:0] ob[NREQ];
        logic         os[NREQ];
        logic [N:0]   exp;
        do_reset();
        for (int k = 0; k < NREQ; k++) begin
            oa[k] = $urandom;
            ob[k] = $urandom;
            os[k] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 40 && rids.size() < 6; c++) begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++) set_req(k, oa[k], ob[k], os[k]);
            rsp_ready = 1'b1;
            #1;
            if (req_ready !== '0) begin
                chk_cnt++; if (!$onehot(req_ready)) $display("FAIL rr_onehot: got %b want one-hot", req_ready); else pass_cnt++;
                gi = 0;
                for (int k = 0; k < NREQ; k++) if (req_ready[k]) gi = k;
                grants.push_back(gi);
                gcyc.push_back(c);
            end
            if (rsp_valid === 1'b1) begin
                rids.push_back(int'(rsp_id));
                exp = ref_sum(oa[rsp_id], ob[rsp_id], os[rsp_id]);
                chk_cnt++; if ({rsp_cout, rsp_r} !== exp) $display("FAIL rr_result: got %h want %h", {rsp_cout, rsp_r}, exp); else pass_cnt++;
            end
        end
        chk_cnt++; if (rids.size() < 6) $display("FAIL rr_timeout: got %0d responses want 6", rids.size()); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            if (i < grants.size()) begin
                chk_cnt++; if (grants[i] != i % NREQ) $display("FAIL rr_grant[%0d]: got %0d want %0d", i, grants[i], i % NREQ); else pass_cnt++;
            end
            if (i < rids.size()) begin
                chk_cnt++; if (rids[i] != i % NREQ) $display("FAIL rr_rsp_id[%0d]: got %0d want %0d", i, rids[i], i % NREQ); else pass_cnt++;
            end
            if (i > 0 && i < gcyc.size()) begin
                chk_cnt++; if (gcyc[i] - gcyc[i-1] != 3) $display("FAIL rr_spacing[%0d]: got %0d want 3", i, gcyc[i] - gcyc[i-1]); else pass_cnt++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] a, b;
        logic [N:0]   exp;
        do_reset();
        a = $urandom;
        b = $urandom;
        exp = ref_sum(a, b, 1'b0);
        @(negedge clk);
        set_req(1, a, b, 1'b0);
        rsp_ready = 1'b0;
        #1;
        chk_cnt++; if (req_ready !== 4'b0010) $display("FAIL bp_grant: got %b want 0010", req_ready); else pass_cnt++;
        @(negedge clk);
        req_valid = '0;
        set_req(3, ~a, b, 1'b1);
        #1;
        chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL bp_exec_ready: got %b want 0000", req_ready); else pass_cnt++;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rsp_ready = (c == 5);
            #1;
            chk_cnt++;
            if ({rsp_valid, busy, req_ready, rsp_id, rsp_cout, rsp_r} !== {1'b1, 1'b1, 4'b0000, 2'd1, exp})
                $display("FAIL bp_hold[%0d]: got v=%b busy=%b rdy=%b id=%0d r=%h want 1 1 0000 1 %h", c, rsp_valid, busy, req_ready, rsp_id, {rsp_cout, rsp_r}, exp);
            else pass_cnt++;
        end
        @(negedge clk);
        #1;
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp_hs_clear: got %b want 0", rsp_valid); else pass_cnt++;
        chk_cnt++; if (req_ready !== 4'b1000) $display("FAIL bp_next_grant: got %b want 1000", req_ready); else pass_cnt++;
        chk_cnt++; if ({rsp_cout, rsp_r} !== exp) $display("FAIL bp_keep_last: got %h want %h", {rsp_cout, rsp_r}, exp); else pass_cnt++;
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] a, b;
        logic [N:0]   exp;
        do_reset();
        a = $urandom;
        b = $urandom;
        exp = ref_sum(a, b, 1'b1);
        @(negedge clk);
        set_req(3, a, b, 1'b1);
        rsp_ready = 1'b1;
        #1;
        chk_cnt++; if (req_ready !== 4'b1000) $display("FAIL rm_grant: got %b want 1000", req_ready); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL rm_ready_in_reset: got %b want 0000", req_ready); else pass_cnt++;
        @(negedge clk);
        #1;
        chk_cnt++;
        if ({rsp_valid, busy, rsp_id, rsp_r, rsp_cout} !== '0)
            $display("FAIL rm_abandon: got v=%b busy=%b id=%0d r=%h c=%b want all 0", rsp_valid, busy, rsp_id, rsp_r, rsp_cout);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_cnt++; if (req_ready !== 4'b1000) $display("FAIL rm_regrant: got %b want 1000", req_ready); else pass_cnt++;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        chk_cnt++;
        if ({rsp_valid, rsp_id, rsp_cout, rsp_r} !== {1'b1, 2'd3, exp})
            $display("FAIL rm_rsp: got v=%b id=%0d r=%h want 1 3 %h", rsp_valid, rsp_id, {rsp_cout, rsp_r}, exp);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic            pend[NREQ];
        logic [N-1:0]    pa[NREQ];
        logic [N-1:0]    pb[NREQ];
        logic            ps[NREQ];
        int              mptr = 0;
        int              mode = 0;   // 0 idle, 1 operation in flight, 2 response offered
        int              eg, idx, eid;
        logic [N-1:0]    ea, eb;
        logic            es;
        logic [NREQ-1:0] exp_ready;
        logic [N:0]      exp;
        do_reset();
        for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
        eid = 0; ea = '0; eb = '0; es = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k] = 1'b1;
                    pa[k]   = pick_operand();
                    pb[k]   = pick_operand();
                    ps[k]   = 1'($urandom_range(0, 1));
                end
                req_valid[k] = pend[k];
                if (pend[k]) begin
                    req_a[k*N +: N] = pa[k];
                    req_b[k*N +: N] = pb[k];
                    req_sub[k]      = ps[k];
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            eg = -1;
            if (mode == 0) begin
                for (int i = 0; i < NREQ; i++) begin
                    idx = (mptr + i) % NREQ;
                    if (eg < 0 && pend[idx]) eg = idx;
                end
            end
            exp_ready = '0;
            if (eg >= 0) exp_ready[eg] = 1'b1;
            chk_cnt++; if (req_ready !== exp_ready) $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, req_ready, exp_ready); else pass_cnt++;
            chk_cnt++;
            if ({rsp_valid, busy} !== {mode == 2, mode != 0})
                $display("FAIL rnd_status[%0d]: got v=%b busy=%b want %b %b", cyc, rsp_valid, busy, mode == 2, mode != 0);
            else pass_cnt++;
            if (mode == 2) begin
                exp = ref_sum(ea, eb, es);
                chk_cnt++;
                if ({rsp_id, rsp_cout, rsp_r} !== {IDW'(eid), exp})
                    $display("FAIL rnd_rsp[%0d]: got id=%0d r=%h want %0d %h", cyc, rsp_id, {rsp_cout, rsp_r}, eid, exp);
                else pass_cnt++;
`ifdef CLA_ARB_OVF_EN
                chk_cnt++; if (rsp_ovf !== ref_ovf(ea, eb, es)) $display("FAIL rnd_ovf[%0d]: got %b want %b", cyc, rsp_ovf, ref_ovf(ea, eb, es)); else pass_cnt++;
`endif
            end
            if (mode == 0 && eg >= 0) begin
                ea = pa[eg]; eb = pb[eg]; es = ps[eg]; eid = eg;
                pend[eg] = 1'b0;
                mptr = (eg + 1) % NREQ;
                mode = 1;
            end else if (mode == 1) begin
                mode = 2;
            end else if (mode == 2 && rsp_ready) begin
                mode = 0;
            end
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_add();
        test_sub_ovf();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/cla_arbiter.md
# cla_arbiter

Round-robin arbiter and sequencer that shares one `CLA` adder/subtractor instance among `NREQ` requesters. Each requester presents operands and an add/sub select with a valid/ready handshake. The arbiter grants one requester, registers its operands into the shared `CLA`, captures the result, and returns it with the requester ID over a valid/ready response channel. It sits between the term-project front-end units and the single shared arithmetic datapath.

## Interface
- `N`, default 32: operand/result width, passed to the `CLA` instance.
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `IDW`, default `$clog2(NREQ)`: requester ID width.

- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: reset, synchronous, active-low.
- `REQ_VALID` in `NREQ`: per-requester request valid.
- `REQ_READY` out `NREQ`: per-requester accept, one-hot or zero.
- `REQ_A` in `NREQ*N`: packed operand A; requester k uses `[k*N +: N]`.
- `REQ_B` in `NREQ*N`: packed operand B, same packing.
- `REQ_SUB` in `NREQ`: per-requester op; 0 = A+B, 1 = A−B.
- `RSP_VALID` out 1: response valid.
- `RSP_READY` in 1: response consumer ready.
- `RSP_ID` out `IDW`: ID of the requester that owns the response.
- `RSP_R` out `N`: result.
- `RSP_COUT` out 1: carry out of the `CLA`. For subtract, 1 = no borrow.
- `RSP_OVF` out 1: signed overflow. Present only with `CLA_ARB_OVF_EN`.
- `BUSY` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset enters IDLE.
- **IDLE**
  - If any `REQ_VALID` is set, pick grantee g: the first set bit scanning upward from `ptr`, wrapping modulo `NREQ`.
  - `REQ_READY[g]` = 1 combinationally in this cycle only. The handshake completes on this edge.
  - On the edge, capture `REQ_A[g]`, `REQ_B[g]` and `REQ_SUB[g]` into the operand registers, capture g into the ID register, set `ptr` = (g+1) mod `NREQ`, and go to EXEC.
  - If no request is valid, stay in IDLE, keep all `REQ_READY` at 0 and leave `ptr` unchanged.
- **EXEC**
  - The `CLA` (A = opA, B = opB, ADD_SUB = opSub) evaluates combinationally from the operand registers.
  - On the edge, capture `R` → `RSP_R` and `COUT` → `RSP_COUT` (and OVF), load `RSP_ID`, set `RSP_VALID` = 1, and go to RESP.
- **RESP**
  - Hold `RSP_*` stable while `RSP_VALID` = 1 and `RSP_READY` = 0.
  - On `RSP_VALID & RSP_READY`, clear `RSP_VALID` and go to IDLE.
  - `RSP_R`, `RSP_COUT`, `RSP_ID` and `RSP_OVF` keep their last values after the handshake.
- `REQ_READY` is all-zero outside IDLE. Requests raised during EXEC/RESP wait.
- Requesters must hold `REQ_VALID` and their operands stable until `REQ_READY`. The arbiter never drops a pending request.
- Arithmetic is modulo 2^N.
  - Add: `RSP_R` = A+B, `RSP_COUT` = carry out of bit N−1.
  - Sub: `RSP_R` = A+~B+1, `RSP_COUT` = 1 iff A ≥ B unsigned.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NREQ−1,0,…. No requester waits more than `NREQ`−1 other grants.

## Timing
- Reset values: state IDLE, `ptr` = 0, `REQ_READY` = 0, `RSP_VALID` = 0, `RSP_ID` = 0, `RSP_R` = 0, `RSP_COUT` = 0, `RSP_OVF` = 0, `BUSY` = 0.
- Latency:
  - Request accepted at edge T.
  - `RSP_VALID` rises after edge T+1.
  - With `RSP_READY` held high, the response handshake completes at edge T+2, and the next grant can complete at edge T+3.
  - Peak throughput is 1 operation per 3 cycles.
- The `CLA` path (operand regs → `RSP_R`) must close in one cycle at `N` = 32.
- `RSP_READY` high while `RSP_VALID` = 0 is ignored.
- Reset asserted in any state at edge T: the in-flight operation is abandoned with no response, `ptr` returns to 0, and all outputs take reset values after edge T.
- In the same cycle the FSM is in RESP with a handshake and new requests arrive: go to IDLE first. The grant happens in the following cycle.

## Configuration
- `CLA_ARB_OVF_EN` defined:
  - The `RSP_OVF` port and its register exist.
  - `RSP_OVF` = (opA[N−1] == B_eff[N−1]) && (`RSP_R`[N−1] != opA[N−1]), where B_eff = opB ^ {N{opSub}}.
  - It is captured in EXEC alongside `RSP_R`.
- `CLA_ARB_OVF_EN` undefined: no `RSP_OVF` port or logic. All other behaviour is identical.

## Test plan
- **Reset:** hold `RST_N` = 0 for 2 cycles with `REQ_VALID` = 4'b1111 → `REQ_READY` = 0, `RSP_VALID` = 0, `BUSY` = 0, all `RSP_*` = 0.
- **Single add:** req0 A = 32'hFFFF_FFFF, B = 1, SUB = 0, `RSP_READY` = 1 → `REQ_READY[0]` for one cycle; two cycles later `RSP_VALID` with `RSP_ID` = 0, `RSP_R` = 0, `RSP_COUT` = 1, `RSP_OVF` = 0.
- **Subtract and overflow:**
  - req2 A = 5, B = 7, SUB = 1 → `RSP_R` = 32'hFFFF_FFFE, `RSP_COUT` = 0, `RSP_ID` = 2.
  - Then req1 A = 32'h7FFF_FFFF, B = 1, SUB = 0 → `RSP_R` = 32'h8000_0000, `RSP_OVF` = 1 (with the macro).
- **Round robin:** all four requesters continuously valid → grant order 0,1,2,3,0,1; `RSP_ID` follows the same order; grants exactly 3 cycles apart with `RSP_READY` = 1.
- **Backpressure:** `RSP_READY` = 0 for 5 cycles during RESP → `RSP_*` stable, `REQ_READY` = 0, `BUSY` = 1; on `RSP_READY` = 1, one handshake, then the next grant one cycle later.
- **Reset mid-operation:** assert `RST_N` = 0 in EXEC of a req3 operation → no `RSP_VALID`; after release, req3 (still valid) is re-granted because `ptr` = 0 and req0..2 are idle.
